// File: rtl/spi_audio_pkg.sv
// rtl/spi_audio_pkg.sv - shared types, default parameters and helpers for the SPI audio receiver
package spi_audio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PUSH
    } rx_state_t;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_CHANNELS    = 2;
    localparam int DEF_FIFO_DEPTH  = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_MSB_FIRST   = 1;
    localparam int DEF_SAMPLE_EDGE = 0;

    // Mono still carries a one-bit tag so the port never collapses to zero width.
    function automatic int chan_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with same-cycle push+pop when full
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_drop,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_rd_ok;
    logic             w_wr_ok;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_rd_ok = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign w_wr_ok = i_push && (!o_full || w_rd_ok);
    assign o_drop  = i_push && !w_wr_ok;
    assign o_level = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/spi_audio_rx_fifo.sv
// rtl/spi_audio_rx_fifo.sv - SPI-slave PCM deserialiser with channel tagging and output FIFO
module spi_audio_rx_fifo
    import spi_audio_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MSB_FIRST   = DEF_MSB_FIRST,
    parameter int SAMPLE_EDGE = DEF_SAMPLE_EDGE
) (
    input  logic                              clock_max,
    input  logic                              reset,
    input  logic                              sclk_in,
    input  logic                              mosi_in,
    input  logic                              active_in,
    input  logic                              clear_errors,
    input  logic                              sample_ready,
    output logic [DATA_W-1:0]                 sample_data,
    output logic [chan_width(CHANNELS)-1:0]   sample_chan,
    output logic                              sample_valid,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              overflow,
    output logic                              frame_error
);

    localparam int CHAN_W = chan_width(CHANNELS);
    localparam int CNT_W  = $clog2(DATA_W) + 1;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_act_sync;
    logic                   r_sclk_d;
    logic                   r_sclk_dd;
    logic                   r_mosi_d;
    logic                   r_act_d;
    logic                   r_strobe;
    logic                   r_bit;
    logic                   r_act_q;
    logic                   r_act_qd;

    rx_state_t              r_state;
    rx_state_t              w_state_next;
    logic [DATA_W-1:0]      r_shift;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [CHAN_W-1:0]      r_chan;
    logic [DATA_W-1:0]      r_push_word;
    logic [CHAN_W-1:0]      r_push_chan;
    logic                   r_ovf;
    logic                   r_ferr;

    logic                   w_edge;
    logic                   w_act_rise;
    logic                   w_last_bit;
    logic [DATA_W-1:0]      w_shift_next;
    logic [CHAN_W-1:0]      w_chan_next;
    logic                   w_start;
    logic                   w_shift_en;
    logic                   w_latch;
    logic                   w_push;
    logic                   w_set_ferr;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [CHAN_W+DATA_W-1:0] w_rd_word;

    // Edge detect, mosi and active share one pipeline so they stay cycle-aligned with the strobe.
    assign w_edge       = (SAMPLE_EDGE == 0) ? (r_sclk_d & ~r_sclk_dd) : (~r_sclk_d & r_sclk_dd);
    assign w_act_rise   = r_act_q & ~r_act_qd;
    assign w_last_bit   = (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign w_shift_next = (MSB_FIRST != 0) ? {r_shift[DATA_W-2:0], r_bit}
                                           : {r_bit, r_shift[DATA_W-1:1]};
    assign w_chan_next  = (r_chan == CHAN_W'(CHANNELS - 1)) ? '0 : r_chan + CHAN_W'(1);

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift_en   = 1'b0;
        w_latch      = 1'b0;
        w_push       = 1'b0;
        w_set_ferr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_act_rise) begin
                    w_start      = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_strobe) begin
                    w_shift_en = 1'b1;
                    if (w_last_bit) begin
                        w_latch      = 1'b1;
                        w_state_next = PUSH;
                    end else if (!r_act_q) begin
                        w_set_ferr   = 1'b1;
                        w_state_next = IDLE;
                    end
                end else if (!r_act_q) begin
                    w_set_ferr   = (r_bit_cnt != '0);
                    w_state_next = IDLE;
                end
            end
            PUSH: begin
                w_push       = 1'b1;
                w_state_next = r_act_q ? SHIFT : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_max or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_act_sync  <= '0;
            r_sclk_d    <= 1'b0;
            r_sclk_dd   <= 1'b0;
            r_mosi_d    <= 1'b0;
            r_act_d     <= 1'b0;
            r_strobe    <= 1'b0;
            r_bit       <= 1'b0;
            r_act_q     <= 1'b0;
            r_act_qd    <= 1'b0;
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_chan      <= '0;
            r_push_word <= '0;
            r_push_chan <= '0;
            r_ovf       <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
            r_act_sync  <= {r_act_sync[SYNC_STAGES-2:0], active_in};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_sclk_dd   <= r_sclk_d;
            r_mosi_d    <= r_mosi_sync[SYNC_STAGES-1];
            r_act_d     <= r_act_sync[SYNC_STAGES-1];
            r_strobe    <= w_edge;
            r_bit       <= r_mosi_d;
            r_act_q     <= r_act_d;
            r_act_qd    <= r_act_q;
            r_state     <= w_state_next;

            if (w_start) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_chan    <= '0;
            end
            if (w_shift_en) begin
                r_shift   <= w_shift_next;
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_latch) begin
                r_push_word <= w_shift_next;
                r_push_chan <= r_chan;
            end
            if (w_push) begin
                r_bit_cnt <= '0;
                r_chan    <= w_chan_next;
            end

            // A new event wins over a coincident clear.
            r_ovf  <= w_drop     | (r_ovf  & ~clear_errors);
            r_ferr <= w_set_ferr | (r_ferr & ~clear_errors);
        end
    end

    sync_fifo #(
        .WIDTH (CHAN_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clock_max),
        .i_reset (reset),
        .i_push  (w_push),
        .i_wdata ({r_push_chan, r_push_word}),
        .i_pop   (sample_ready),
        .o_rdata (w_rd_word),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop),
        .o_level (fifo_level)
    );

    assign sample_data  = w_rd_word[DATA_W-1:0];
    assign sample_chan  = w_rd_word[DATA_W +: CHAN_W];
    assign sample_valid = !w_empty;
    assign overflow     = r_ovf;
    assign frame_error  = r_ferr;

endmodule
